// File: rtl/tt_pwm_multichannel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tt_pwm_multichannel                                                      |
// | Multi-channel PWM on the TinyTapeout pin frame: serial duty load,        |
// | period-boundary commit, prescaler. Option: PWM_CENTER_ALIGN_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tt_pwm_multichannel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int               c_sr_bits = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_cnt_one = WIDTH'(1);

  logic       w_clk;
  logic       w_rst_n;
  logic       w_sdi;
  logic       w_shift_en;
  logic       w_commit;
  logic       w_enable;
  logic [1:0] w_ps;

  assign w_clk      = io_in[0];
  assign w_rst_n    = io_in[1];
  assign w_sdi      = io_in[2];
  assign w_shift_en = io_in[3];
  assign w_commit   = io_in[4];
  assign w_enable   = io_in[5];
  assign w_ps       = io_in[7:6];

  logic [c_sr_bits-1:0] r_shift;
  logic [c_sr_bits-1:0] r_duty;
  logic                 r_commit_q;
  logic                 r_pending;
  logic [2:0]           r_div;
  logic [WIDTH-1:0]     r_cnt;
  logic [CHANNELS-1:0]  r_pwm;
  logic                 r_strobe;
  logic                 r_pending_out;

  logic [2:0]           w_div_mask;
  logic                 w_tick;
  logic                 w_wrap;
  logic [WIDTH-1:0]     w_cnt_next;
  logic                 w_commit_edge;
  logic                 w_xfer;
  logic [CHANNELS-1:0]  w_pwm_cmp;

  always_comb begin
    w_div_mask = 3'b000;
    case (w_ps)
      2'd0:    w_div_mask = 3'b000;
      2'd1:    w_div_mask = 3'b001;
      2'd2:    w_div_mask = 3'b011;
      default: w_div_mask = 3'b111;
    endcase
  end

  assign w_tick = w_enable & ((r_div & w_div_mask) == w_div_mask);

`ifdef PWM_CENTER_ALIGN_EN
  logic r_dir_down;
  logic w_dir_next;

  // Triangle count: up to max, then down to 1; the down-count at 1 is the wrap.
  assign w_wrap = w_tick & r_dir_down & (r_cnt == c_cnt_one);

  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir_down;
    if (!w_enable) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
    end else if (w_tick) begin
      if (!r_dir_down) begin
        if (r_cnt == c_cnt_max) begin
          w_cnt_next = c_cnt_max - c_cnt_one;
          w_dir_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + c_cnt_one;
        end
      end else begin
        w_cnt_next = r_cnt - c_cnt_one;
        if (r_cnt == c_cnt_one) w_dir_next = 1'b0;
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_dir_down <= 1'b0;
    else          r_dir_down <= w_dir_next;
  end
`else
  assign w_wrap = w_tick & (r_cnt == c_cnt_max);

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_enable)   w_cnt_next = '0;
    else if (w_tick) w_cnt_next = r_cnt + c_cnt_one;
  end
`endif

  // A disabled block takes a pending (or same-cycle) commit immediately.
  assign w_commit_edge = w_commit & ~r_commit_q;
  assign w_xfer        = (w_wrap | ~w_enable) & (r_pending | w_commit_edge);

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      assign w_pwm_cmp[ch] = w_enable & (r_cnt < r_duty[ch*WIDTH +: WIDTH]);
    end
  endgenerate

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift       <= '0;
      r_duty        <= '0;
      r_commit_q    <= 1'b0;
      r_pending     <= 1'b0;
      r_div         <= 3'd0;
      r_cnt         <= '0;
      r_pwm         <= '0;
      r_strobe      <= 1'b0;
      r_pending_out <= 1'b0;
    end else begin
      r_commit_q <= w_commit;
      if (w_shift_en) r_shift <= {r_shift[c_sr_bits-2:0], w_sdi};
      if (w_xfer) begin
        r_duty    <= r_shift;
        r_pending <= 1'b0;
      end else if (w_commit_edge) begin
        r_pending <= 1'b1;
      end
      r_div         <= w_enable ? r_div + 3'd1 : 3'd0;
      r_cnt         <= w_cnt_next;
      r_pwm         <= w_pwm_cmp;
      r_strobe      <= w_wrap;
      r_pending_out <= r_pending;
    end
  end

  always_comb begin
    io_out                 = 8'h00;
    io_out[CHANNELS-1:0]   = r_pwm;
    io_out[6]              = r_strobe;
    io_out[7]              = r_pending_out;
  end

endmodule
`default_nettype wire
